// File: rtl/alu_result_stage_pkg.sv
// Shared definitions for the ALU result stage.
//   - ALU opcode encodings (AND/OR/ADD/SUB/SLT/NOR/SLL/SRL/SRA)
//   - Flag bit positions inside the stage payload, counted from just above Z
//   - Occupancy states of the 2-entry skid buffer
package alu_result_stage_pkg;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SLL = 4'b0011;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_SRL = 4'b1000;
  localparam logic [3:0] OP_SRA = 4'b1001;
  localparam logic [3:0] OP_NOR = 4'b1100;

  // Payload layout: {op, ovf, neg, zero, z}
  localparam int unsigned FLAG_ZERO = 0;
  localparam int unsigned FLAG_NEG  = 1;
  localparam int unsigned FLAG_OVF  = 2;
  localparam int unsigned FLAG_W    = 3;

  typedef enum logic [1:0] {
    SKID_EMPTY = 2'd0,
    SKID_ONE   = 2'd1,
    SKID_TWO   = 2'd2
  } skid_state_e;

endpackage

// File: rtl/alu_result_stage_result_skid.sv
// result_skid: generic 2-entry valid/ready skid buffer.
//   MAIN drives the outputs; SKID holds one extra entry while MAIN is stalled.
//   in_ready is a register, so there is no combinational path from out_ready.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   in_valid/in_ready   upstream handshake
//   in_data [PW]        upstream payload
//   out_valid/out_ready downstream handshake
//   out_data [PW]       payload of the MAIN entry
module result_skid
  import alu_result_stage_pkg::*;
#(
  parameter int unsigned PW = 39
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [PW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [PW-1:0] out_data
);

  skid_state_e   state_q, state_d;
  logic [PW-1:0] main_q, main_d;
  logic [PW-1:0] skid_q, skid_d;
  logic          rdy_q, rdy_d;
  logic          accept, emit;

  assign accept = in_valid && rdy_q;
  assign emit   = (state_q != SKID_EMPTY) && out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      SKID_EMPTY: begin
        if (accept) begin
          state_d = SKID_ONE;
          main_d  = in_data;
        end
      end
      SKID_ONE: begin
        if (accept && emit) begin
          main_d = in_data;
        end else if (accept) begin
          state_d = SKID_TWO;
          skid_d  = in_data;
        end else if (emit) begin
          state_d = SKID_EMPTY;
        end
      end
      SKID_TWO: begin
        // rdy_q is low here, so no accept can coincide with the drain
        if (emit) begin
          state_d = SKID_ONE;
          main_d  = skid_q;
        end
      end
      default: state_d = SKID_EMPTY;
    endcase
    rdy_d = (state_d != SKID_TWO);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= SKID_EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
      rdy_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
      rdy_q   <= rdy_d;
    end
  end

  assign in_ready  = rdy_q;
  assign out_valid = (state_q != SKID_EMPTY);
  assign out_data  = main_q;

endmodule

// File: rtl/alu_result_stage.sv
// alu_result_stage: registered output stage behind the ALU datapath.
//   Captures result Z and opcode, derives zero/negative/overflow flags at
//   capture, and hands them downstream through a 2-entry skid buffer.
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   in_valid/in_ready            upstream handshake (in_ready registered)
//   in_z, in_op, in_ovf          ALU result, opcode, raw adder overflow
//   out_valid/out_ready          downstream handshake
//   out_z, out_op                registered result and opcode
//   out_zero, out_neg, out_ovf   flags (ovf only for ADD/SUB)
//   ovf_clr, ovf_sticky          sticky overflow clear / status
// Configuration macro: ALU_STICKY_OVF_EN enables the sticky overflow;
//   without it ovf_sticky is 0 and ovf_clr is ignored.
module alu_result_stage
  import alu_result_stage_pkg::*;
#(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned OP_WIDTH = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [WIDTH-1:0]    in_z,
  input  logic [OP_WIDTH-1:0] in_op,
  input  logic                in_ovf,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [WIDTH-1:0]    out_z,
  output logic [OP_WIDTH-1:0] out_op,
  output logic                out_zero,
  output logic                out_neg,
  output logic                out_ovf,
  input  logic                ovf_clr,
  output logic                ovf_sticky
);

  localparam int unsigned PW = OP_WIDTH + FLAG_W + WIDTH;

  logic          ovf_qual;
  logic [PW-1:0] in_payload, out_payload;

  assign ovf_qual   = in_ovf && ((in_op == OP_WIDTH'(OP_ADD)) || (in_op == OP_WIDTH'(OP_SUB)));
  assign in_payload = {in_op, ovf_qual, in_z[WIDTH-1], (in_z == '0), in_z};

  result_skid #(.PW(PW)) u_skid (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_payload),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_payload)
  );

  assign out_z    = out_payload[WIDTH-1:0];
  assign out_zero = out_payload[WIDTH+FLAG_ZERO];
  assign out_neg  = out_payload[WIDTH+FLAG_NEG];
  assign out_ovf  = out_payload[WIDTH+FLAG_OVF];
  assign out_op   = out_payload[PW-1 -: OP_WIDTH];

`ifdef ALU_STICKY_OVF_EN
  logic sticky_q, sticky_d;

  // Set has priority over clear in the same cycle
  always_comb begin
    sticky_d = sticky_q;
    if (out_valid && out_ready && out_ovf) begin
      sticky_d = 1'b1;
    end else if (ovf_clr) begin
      sticky_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sticky_q <= 1'b0;
    end else begin
      sticky_q <= sticky_d;
    end
  end

  assign ovf_sticky = sticky_q;
`else
  logic unused_ovf_clr;
  assign unused_ovf_clr = ovf_clr;
  assign ovf_sticky     = 1'b0;
`endif

endmodule

// File: tb/tb_alu_result_stage.sv
module tb_alu_result_stage;
  import alu_result_stage_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_z;
  logic [3:0]  in_op;
  logic        in_ovf;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_z;
  logic [3:0]  out_op;
  logic        out_zero;
  logic        out_neg;
  logic        out_ovf;
  logic        ovf_clr;
  logic        ovf_sticky;

  int unsigned n_total = 0;
  int unsigned n_bad   = 0;

`ifdef ALU_STICKY_OVF_EN
  localparam logic STK = 1'b1;
`else
  localparam logic STK = 1'b0;
`endif

  always #5 clk = ~clk;

  alu_result_stage #(.WIDTH(32), .OP_WIDTH(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_z       (in_z),
    .in_op      (in_op),
    .in_ovf     (in_ovf),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_z      (out_z),
    .out_op     (out_op),
    .out_zero   (out_zero),
    .out_neg    (out_neg),
    .out_ovf    (out_ovf),
    .ovf_clr    (ovf_clr),
    .ovf_sticky (ovf_sticky)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge, then settle so outputs are sampled away from it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] z, input logic [3:0] op, input logic ovf);
    in_valid = v;
    in_z     = z;
    in_op    = op;
    in_ovf   = ovf;
  endtask

  initial begin
    rst = 1'b1; out_ready = 1'b0; ovf_clr = 1'b0;
    drive(1'b1, 32'h1234, OP_ADD, 1'b1);

    // 1) reset with in_valid high
    step(); step();
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_ready", 32'(in_ready), 32'd1);
    check("rst_z", out_z, 32'd0);
    check("rst_op", 32'(out_op), 32'd0);
    check("rst_flags", {29'd0, out_ovf, out_neg, out_zero}, 32'd0);
    check("rst_sticky", 32'(ovf_sticky), 32'd0);
    rst = 1'b0;
    drive(1'b0, 32'h0, OP_AND, 1'b0);
    step();
    check("post_rst_valid", 32'(out_valid), 32'd0);

    // 2) streaming at one result per cycle
    out_ready = 1'b1;
    drive(1'b1, 32'hFFFF_FFFF, OP_SLL, 1'b1);
    step();
    check("s1_valid", 32'(out_valid), 32'd1);
    check("s1_z", out_z, 32'hFFFF_FFFF);
    check("s1_op", 32'(out_op), 32'(OP_SLL));
    check("s1_flags", {29'd0, out_ovf, out_neg, out_zero}, 32'b010);
    check("s1_ready", 32'(in_ready), 32'd1);
    drive(1'b1, 32'h0, OP_SRL, 1'b0);
    step();
    check("s2_valid", 32'(out_valid), 32'd1);
    check("s2_z", out_z, 32'h0);
    check("s2_op", 32'(out_op), 32'(OP_SRL));
    check("s2_flags", {29'd0, out_ovf, out_neg, out_zero}, 32'b001);
    drive(1'b0, 32'h0, OP_AND, 1'b0);
    step();
    check("s3_drained", 32'(out_valid), 32'd0);

    // 3) stall: fill both entries, third push refused, then drain in order
    out_ready = 1'b0;
    drive(1'b1, 32'd1, OP_AND, 1'b0);
    step();
    check("f1_valid", 32'(out_valid), 32'd1);
    check("f1_z", out_z, 32'd1);
    check("f1_ready", 32'(in_ready), 32'd1);
    drive(1'b1, 32'd2, OP_OR, 1'b0);
    step();
    check("f2_z_held", out_z, 32'd1);
    check("f2_ready", 32'(in_ready), 32'd0);
    drive(1'b1, 32'd3, OP_NOR, 1'b0);
    step();
    check("f3_z_held", out_z, 32'd1);
    check("f3_op_held", 32'(out_op), 32'(OP_AND));
    check("f3_ready", 32'(in_ready), 32'd0);
    drive(1'b0, 32'h0, OP_AND, 1'b0);
    out_ready = 1'b1;
    step();
    check("d1_valid", 32'(out_valid), 32'd1);
    check("d1_z", out_z, 32'd2);
    check("d1_op", 32'(out_op), 32'(OP_OR));
    check("d1_ready", 32'(in_ready), 32'd1);
    step();
    check("d2_empty", 32'(out_valid), 32'd0);
    step();
    check("d3_empty", 32'(out_valid), 32'd0);

    // 4) overflow qualified by opcode, unknown opcode passes through
    drive(1'b1, 32'h8000_0000, OP_ADD, 1'b1);
    step();
    check("o_add_ovf", 32'(out_ovf), 32'd1);
    check("o_add_neg", 32'(out_neg), 32'd1);
    drive(1'b1, 32'd5, OP_SUB, 1'b1);
    step();
    check("o_sub_ovf", 32'(out_ovf), 32'd1);
    check("o_sub_z", out_z, 32'd5);
    drive(1'b1, 32'h10, OP_SLL, 1'b1);
    step();
    check("o_sll_ovf", 32'(out_ovf), 32'd0);
    drive(1'b1, 32'd1, OP_SLT, 1'b1);
    step();
    check("o_slt_ovf", 32'(out_ovf), 32'd0);
    drive(1'b1, 32'h0, 4'hF, 1'b1);
    step();
    check("o_unk_op", 32'(out_op), 32'hF);
    check("o_unk_flags", {29'd0, out_ovf, out_neg, out_zero}, 32'b001);
    drive(1'b0, 32'h0, OP_AND, 1'b0);
    step();
    check("o_sticky", 32'(ovf_sticky), 32'(STK));

    // 5) reset while both entries are held
    out_ready = 1'b0;
    drive(1'b1, 32'hAAAA_0001, OP_OR, 1'b0);
    step();
    drive(1'b1, 32'hAAAA_0002, OP_OR, 1'b0);
    step();
    check("r_pre_ready", 32'(in_ready), 32'd0);
    drive(1'b0, 32'h0, OP_AND, 1'b0);
    rst = 1'b1;
    step();
    check("r_valid", 32'(out_valid), 32'd0);
    check("r_ready", 32'(in_ready), 32'd1);
    check("r_z", out_z, 32'd0);
    check("r_sticky", 32'(ovf_sticky), 32'd0);
    rst = 1'b0;
    out_ready = 1'b1;
    for (int unsigned i = 0; i < 3; i++) begin
      step();
      check("r_no_stale", 32'(out_valid), 32'd0);
    end

    // 6) sticky overflow: set wins over clear, clear alone clears
    drive(1'b1, 32'd7, OP_ADD, 1'b1);
    step();
    check("k1_sticky_pre", 32'(ovf_sticky), 32'd0);
    drive(1'b0, 32'h0, OP_AND, 1'b0);
    step();
    check("k1_sticky_set", 32'(ovf_sticky), 32'(STK));
    drive(1'b1, 32'd8, OP_ADD, 1'b1);
    step();
    drive(1'b0, 32'h0, OP_AND, 1'b0);
    ovf_clr = 1'b1;
    step();
    check("k2_set_wins", 32'(ovf_sticky), 32'(STK));
    step();
    check("k3_clr", 32'(ovf_sticky), 32'd0);
    ovf_clr = 1'b0;

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
